// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight and
// parks the returned word in a one-entry IF/ID register for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic        kill;
    logic        kill_n;
    logic        valid_n;
    logic [31:0] inst_n;
    logic [31:0] pc_out_n;

    logic        req_fire;
    logic        rsp_take;
    logic        fill;
    logic        outstanding;

    // Only ask for a word when the slot is free by the time it returns.
    assign imem_req_valid = rst_n & (state == S_REQ) &
                            (~inst_valid | inst_ready);
    assign imem_req_addr  = pc;

    assign req_fire    = imem_req_valid & imem_req_ready;
    assign rsp_take    = (state == S_WAIT) & imem_rsp_valid;
    assign fill        = rsp_take & ~kill;
    assign outstanding = ((state == S_WAIT) & ~imem_rsp_valid) | req_fire;

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        kill_n   = kill;
        valid_n  = inst_valid;
        inst_n   = inst_out;
        pc_out_n = pc_out;

        if (redirect_valid) begin
            pc_n    = redirect_pc & ~32'h0000_0003;
            valid_n = 1'b0;
            inst_n  = NOP_INST;
            // A read still in flight must be discarded when it lands.
            state_n = outstanding ? S_WAIT : S_REQ;
            kill_n  = outstanding;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (req_fire) begin
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_n = S_REQ;
                        kill_n  = 1'b0;
                    end
                end
            endcase

            if (fill) begin
                valid_n  = 1'b1;
                inst_n   = imem_rsp_data;
                pc_out_n = pc;
                pc_n     = pc + 32'd4;
            end else if (inst_valid && inst_ready) begin
                valid_n = 1'b0;
                inst_n  = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            inst_valid <= 1'b0;
            inst_out   <= NOP_INST;
            pc_out     <= RESET_PC;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            kill       <= kill_n;
            inst_valid <= valid_n;
            inst_out   <= inst_n;
            pc_out     <= pc_out_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-configurable imem model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;

    int checks = 0;
    int errors = 0;

    logic        pending;
    int          cnt;
    int          lat;
    logic [31:0] paddr;

    fetch_unit #(
        .RESET_PC(32'h0000_0100),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .pc_out        (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update imem model after.
    task automatic tick();
        logic        fire;
        logic        rsp_was;
        logic        rst_was;
        logic [31:0] a;
        #1;
        fire    = imem_req_valid & imem_req_ready;
        a       = imem_req_addr;
        rsp_was = imem_rsp_valid;
        rst_was = rst_n;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (!rst_was) begin
            pending = 1'b0;
        end else begin
            if (rsp_was) pending = 1'b0;
            if (fire) begin
                pending = 1'b1;
                cnt     = lat;
                paddr   = a;
            end
        end
        if (pending && cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(paddr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            if (pending) cnt--;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        pending        = 1'b0;
        cnt            = 0;
        lat            = 0;
        paddr          = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_out", inst_out, 32'h13);
        chk("rst_pc_out", pc_out, 32'h100);

        // Streaming fetch, zero-wait memory
        rst_n = 1'b1;
        #1;
        chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c1_addr", imem_req_addr, 32'h100);
        tick();
        chk("c2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("c2_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("c3_inst_valid", 32'(inst_valid), 32'd1);
        chk("c3_inst", inst_out, mem_word(32'h100));
        chk("c3_pc_out", pc_out, 32'h100);
        chk("c3_addr", imem_req_addr, 32'h104);
        chk("c3_req_valid", 32'(imem_req_valid), 32'd1);
        tick();
        chk("c4_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("c5_inst", inst_out, mem_word(32'h104));
        chk("c5_pc_out", pc_out, 32'h104);
        chk("c5_addr", imem_req_addr, 32'h108);

        // Decode back-pressure
        inst_ready = 1'b0;
        #1;
        chk("bp_req_valid0", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(inst_valid), 32'd1);
            chk("bp_inst", inst_out, mem_word(32'h104));
            chk("bp_pc_out", pc_out, 32'h104);
            chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        end
        inst_ready = 1'b1;
        #1;
        chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rel_addr", imem_req_addr, 32'h108);
        tick();
        tick();
        chk("rel_inst", inst_out, mem_word(32'h108));
        chk("rel_pc_out", pc_out, 32'h108);
        chk("rel_next_addr", imem_req_addr, 32'h10C);

        // Redirect while waiting on a slow response
        lat = 3;
        tick();
        chk("w_req_valid", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        chk("rw_inst_valid0", 32'(inst_valid), 32'd0);
        chk("rw_req_valid0", 32'(imem_req_valid), 32'd0);
        tick();
        chk("rw_inst_valid1", 32'(inst_valid), 32'd0);
        tick();
        chk("rw_late_rsp", 32'(imem_rsp_valid), 32'd1);
        tick();
        chk("rw_dropped", 32'(inst_valid), 32'd0);
        chk("rw_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rw_addr", imem_req_addr, 32'h200);
        lat = 0;
        tick();
        tick();
        chk("rw_inst", inst_out, mem_word(32'h200));
        chk("rw_pc_out", pc_out, 32'h200);

        // Redirect in the same cycle as the response
        tick();
        chk("rr_rsp", 32'(imem_rsp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        chk("rr_inst_valid", 32'(inst_valid), 32'd0);
        chk("rr_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rr_addr", imem_req_addr, 32'h300);

        // Redirect in the same cycle as a request accept
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        tick();
        chk("ra_req_valid", 32'(imem_req_valid), 32'd0);
        chk("ra_inst_valid0", 32'(inst_valid), 32'd0);
        tick();
        chk("ra_inst_valid1", 32'(inst_valid), 32'd0);
        chk("ra_addr", imem_req_addr, 32'h400);
        tick();
        tick();
        chk("ra_inst", inst_out, mem_word(32'h400));
        chk("ra_pc_out", pc_out, 32'h400);

        // PC wrap at top of address space
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        chk("wr_inst_valid", 32'(inst_valid), 32'd0);
        chk("wr_addr", imem_req_addr, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        tick();
        tick();
        chk("wr_inst", inst_out, mem_word(32'hFFFF_FFFC));
        chk("wr_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wr_next_addr", imem_req_addr, 32'h0);

        // Reset while a slow request is outstanding
        lat = 3;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_req_valid0", 32'(imem_req_valid), 32'd0);
        tick();
        chk("mr_inst_valid", 32'(inst_valid), 32'd0);
        chk("mr_inst_out", inst_out, 32'h13);
        chk("mr_pc_out", pc_out, 32'h100);
        rst_n = 1'b1;
        lat   = 0;
        #1;
        chk("mr_req_valid", 32'(imem_req_valid), 32'd1);
        chk("mr_addr", imem_req_addr, 32'h100);
        tick();
        tick();
        chk("mr_inst", inst_out, mem_word(32'h100));
        chk("mr_valid", 32'(inst_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
